student_apb_arbiter: RTL and testbench

- Round-robin arbiter and APB master sequencer that shares the single APB slave port of a student subsystem between NUM_REQ on-chip requesters.
- Each requester uses a simple valid/ready request channel and a one-cycle response pulse.
- The block converts one accepted request at a time into a compliant APB SETUP/ACCESS transfer and returns PRDATA and PSLVERR to the granted requester.
- Sits between the SoC-side requesters (e.g. debug bridge and core) and the student subsystem APB inputs.

---
 rtl/student_apb_arb_pkg.sv | 14 +
 rtl/student_apb_arbiter_rr_arbiter.sv | 32 +++
 rtl/student_apb_arbiter.sv | 152 +++++++++++++++
 tb/tb_student_apb_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/student_apb_arb_pkg.sv
// Shared types and constants for the student APB arbiter.
// The optional ACCESS timeout is enabled by defining STUDENT_APB_ARB_TIMEOUT_EN.
package student_apb_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;
    localparam int unsigned TO_CNT_W           = 16;

endpackage

// File: rtl/student_apb_arbiter_rr_arbiter.sv
// Combinational round-robin grant: first set request at or after ptr, wrapping.
module rr_arbiter
    import student_apb_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 2,
    localparam int unsigned PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant
);

    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    always_comb begin
        grant   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        if (enable) begin
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                w_idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
                if (!w_found && req[w_idx]) begin
                    grant[w_idx] = 1'b1;
                    w_found      = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/student_apb_arbiter.sv
// Round-robin arbiter sharing one APB master port between NUM_REQ requesters.
// Define STUDENT_APB_ARB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES without PREADY.
module student_apb_arbiter
    import student_apb_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned APB_AW         = 32,
    parameter int unsigned APB_DW         = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                      clk_in,
    input  logic                      reset_int,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*APB_AW-1:0] req_addr,
    input  logic [NUM_REQ*APB_DW-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [APB_DW-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [APB_AW-1:0]         PADDR,
    output logic                      PSEL,
    output logic                      PENABLE,
    output logic                      PWRITE,
    output logic [APB_DW-1:0]         PWDATA,
    input  logic [APB_DW-1:0]         PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    output logic                      busy
);

    localparam int unsigned PTR_W = $clog2(NUM_REQ);

    state_t              r_state, w_state_nxt;
    logic [PTR_W-1:0]    r_rr_ptr, r_gidx, w_gidx, w_ptr_nxt;
    logic [NUM_REQ-1:0]  w_grant, r_gnt, r_rsp_valid;
    logic [APB_AW-1:0]   r_addr, w_addr;
    logic [APB_DW-1:0]   r_wdata, w_wdata, r_rdata;
    logic                r_write, w_write, r_err;
    logic                w_arb_en, w_done, w_abort;

    // Gating with reset keeps req_ready low while the block is held in reset.
    assign w_arb_en = (r_state == IDLE) && reset_int;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req    (req_valid),
        .ptr    (r_rr_ptr),
        .enable (w_arb_en),
        .grant  (w_grant)
    );

    always_comb begin
        w_gidx  = '0;
        w_addr  = '0;
        w_wdata = '0;
        w_write = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_gidx  = i[PTR_W-1:0];
                w_addr  = req_addr[i*APB_AW +: APB_AW];
                w_wdata = req_wdata[i*APB_DW +: APB_DW];
                w_write = req_write[i];
            end
        end
    end

    always_comb begin
        w_ptr_nxt = (r_gidx == PTR_W'(NUM_REQ - 1)) ? '0 : r_gidx + 1'b1;
    end

    assign w_done = (r_state == ACCESS) && PREADY;

`ifdef STUDENT_APB_ARB_TIMEOUT_EN
    logic [TO_CNT_W-1:0] r_to_cnt;

    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            r_to_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_to_cnt <= '0;
        end else if ((r_state == ACCESS) && !PREADY) begin
            r_to_cnt <= r_to_cnt + 1'b1;
        end
    end

    // Abort on the cycle that would make the count reach the limit; PREADY wins ties.
    assign w_abort = (r_state == ACCESS) && !PREADY &&
                     (r_to_cnt == TO_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_abort          = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_grant) w_state_nxt = SETUP;
            SETUP:   w_state_nxt = ACCESS;
            ACCESS:  if (w_done || w_abort) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_int) begin
        if (!reset_int) begin
            r_state     <= IDLE;
            r_rr_ptr    <= '0;
            r_gidx      <= '0;
            r_gnt       <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_write     <= 1'b0;
            r_rsp_valid <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rsp_valid <= '0;
            if (|w_grant) begin
                r_gidx  <= w_gidx;
                r_gnt   <= w_grant;
                r_addr  <= w_addr;
                r_wdata <= w_wdata;
                r_write <= w_write;
            end
            if (w_done) begin
                r_rsp_valid <= r_gnt;
                r_rdata     <= r_write ? '0 : PRDATA;
                r_err       <= PSLVERR;
                r_rr_ptr    <= w_ptr_nxt;
            end else if (w_abort) begin
                r_rsp_valid <= r_gnt;
                r_rdata     <= '0;
                r_err       <= 1'b1;
                r_rr_ptr    <= w_ptr_nxt;
            end
        end
    end

    assign req_ready = w_grant;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign PSEL      = (r_state != IDLE);
    assign PENABLE   = (r_state == ACCESS);
    assign PADDR     = r_addr;
    assign PWRITE    = r_write;
    assign PWDATA    = r_wdata;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_student_apb_arbiter.sv
// Directed self-checking bench for student_apb_arbiter (NUM_REQ=2, 32-bit APB).
// With STUDENT_APB_ARB_TIMEOUT_EN defined it also exercises the ACCESS timeout.
module tb_student_apb_arbiter;

    localparam int NR = 2;
    localparam int AW = 32;
    localparam int DW = 32;
`ifdef STUDENT_APB_ARB_TIMEOUT_EN
    localparam int TB_TO = 4;
`else
    localparam int TB_TO = 255;
`endif

    logic              clk_in = 1'b0;
    logic              reset_int;
    logic [NR-1:0]     req_valid, req_write, req_ready, rsp_valid;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [DW-1:0]     rsp_rdata, PWDATA, PRDATA;
    logic [AW-1:0]     PADDR;
    logic              rsp_err, PSEL, PENABLE, PWRITE, PREADY, PSLVERR, busy;

    int n_checks = 0;
    int n_errors = 0;

    student_apb_arbiter #(
        .NUM_REQ        (NR),
        .APB_AW         (AW),
        .APB_DW         (DW),
        .TIMEOUT_CYCLES (TB_TO)
    ) dut (
        .clk_in    (clk_in),
        .reset_int (reset_int),
        .req_valid (req_valid),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .PADDR     (PADDR),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    logic [1:0]  g;
    logic [31:0] exp_wd, exp_ad;

    initial begin
        reset_int = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        PRDATA    = '0;
        PREADY    = 1'b1;
        PSLVERR   = 1'b0;
        tick();
        check_eq("rst_psel",   64'(PSEL), 64'(0));
        check_eq("rst_pen",    64'(PENABLE), 64'(0));
        check_eq("rst_rspv",   64'(rsp_valid), 64'(0));
        check_eq("rst_busy",   64'(busy), 64'(0));
        check_eq("rst_paddr",  64'(PADDR), 64'(0));
        check_eq("rst_ready",  64'(req_ready), 64'(0));
        tick();
        reset_int = 1'b1;

        // single zero-wait read from requester 0
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr[31:0] = 32'h0000_0010;
        #1;
        check_eq("rd_ready", 64'(req_ready), 64'(2'b01));
        check_eq("rd_c0_psel", 64'(PSEL), 64'(0));
        tick();
        req_valid = 2'b00;
        PRDATA    = 32'hDEAD_BEEF;
        #1;
        check_eq("rd_c1_psel", 64'(PSEL), 64'(1));
        check_eq("rd_c1_pen", 64'(PENABLE), 64'(0));
        check_eq("rd_c1_paddr", 64'(PADDR), 64'(32'h10));
        check_eq("rd_c1_pwrite", 64'(PWRITE), 64'(0));
        check_eq("rd_c1_busy", 64'(busy), 64'(1));
        tick();
        check_eq("rd_c2_psel", 64'(PSEL), 64'(1));
        check_eq("rd_c2_pen", 64'(PENABLE), 64'(1));
        check_eq("rd_c2_rspv", 64'(rsp_valid), 64'(0));
        tick();
        check_eq("rd_c3_rspv", 64'(rsp_valid), 64'(2'b01));
        check_eq("rd_c3_rdata", 64'(rsp_rdata), 64'(32'hDEAD_BEEF));
        check_eq("rd_c3_err", 64'(rsp_err), 64'(0));
        check_eq("rd_c3_psel", 64'(PSEL), 64'(0));
        check_eq("rd_c3_busy", 64'(busy), 64'(0));
        tick();
        check_eq("rd_c4_rspv", 64'(rsp_valid), 64'(0));
        check_eq("rd_c4_hold", 64'(rsp_rdata), 64'(32'hDEAD_BEEF));

        // both requesters continuously valid; pointer is 1 after the read above
        g = 2'd1;
        req_valid = 2'b11;
        req_write = 2'b11;
        for (int n = 0; n < 8; n++) begin
            req_addr[31:0]   = 32'h100 + 32'(n * 4);
            req_addr[63:32]  = 32'h200 + 32'(n * 4);
            req_wdata[31:0]  = 32'hA000_0000 + 32'(n);
            req_wdata[63:32] = 32'hB000_0000 + 32'(n);
            exp_wd = (g == 2'd1) ? 32'hB000_0000 + 32'(n) : 32'hA000_0000 + 32'(n);
            exp_ad = (g == 2'd1) ? 32'h200 + 32'(n * 4) : 32'h100 + 32'(n * 4);
            #1;
            check_eq("rr_ready", 64'(req_ready), 64'(2'b01 << g));
            tick();
            req_wdata = '1;
            req_addr  = '1;
            #1;
            check_eq("rr_pwdata_s", 64'(PWDATA), 64'(exp_wd));
            check_eq("rr_paddr_s", 64'(PADDR), 64'(exp_ad));
            tick();
            check_eq("rr_pwdata_a", 64'(PWDATA), 64'(exp_wd));
            check_eq("rr_pwrite", 64'(PWRITE), 64'(1));
            tick();
            check_eq("rr_rspv", 64'(rsp_valid), 64'(2'b01 << g));
            g = 2'd1 - g;
        end
        req_valid = 2'b00;

        // write from requester 1 with three wait states and a slave error
        tick();
        req_valid = 2'b10;
        req_write = 2'b10;
        req_addr[63:32]  = 32'h0000_0044;
        req_wdata[63:32] = 32'h1234_5678;
        PREADY = 1'b0;
        #1;
        check_eq("ws_ready", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = 2'b00;
        tick();
        for (int k = 0; k < 4; k++) begin
            check_eq("ws_pen", 64'(PENABLE), 64'(1));
            check_eq("ws_paddr", 64'(PADDR), 64'(32'h44));
            check_eq("ws_pwdata", 64'(PWDATA), 64'(32'h1234_5678));
            check_eq("ws_rspv0", 64'(rsp_valid), 64'(0));
            if (k == 3) begin
                PREADY  = 1'b1;
                PSLVERR = 1'b1;
            end
            tick();
        end
        check_eq("ws_rspv", 64'(rsp_valid), 64'(2'b10));
        check_eq("ws_err", 64'(rsp_err), 64'(1));
        check_eq("ws_rdata", 64'(rsp_rdata), 64'(0));
        PSLVERR = 1'b0;

        // requester 1 pulses for one cycle while requester 0 is in flight
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr[31:0] = 32'h0000_0020;
        PRDATA = 32'h0BAD_F00D;
        #1;
        check_eq("pl_ready0", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b10;
        #1;
        check_eq("pl_ready_setup", 64'(req_ready), 64'(0));
        tick();
        req_valid = 2'b00;
        #1;
        check_eq("pl_ready_access", 64'(req_ready), 64'(0));
        tick();
        check_eq("pl_rspv", 64'(rsp_valid), 64'(2'b01));
        check_eq("pl_rdata", 64'(rsp_rdata), 64'(32'h0BAD_F00D));
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq("pl_no_rsp1", 64'(rsp_valid), 64'(0));
            check_eq("pl_idle", 64'(busy), 64'(0));
        end

        // reset during ACCESS of a requester-1 transfer (pointer is 1 here)
        req_valid = 2'b10;
        req_write = 2'b00;
        PREADY = 1'b0;
        #1;
        check_eq("ra_ready", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = 2'b00;
        tick();
        check_eq("ra_pen_pre", 64'(PENABLE), 64'(1));
        #2;
        reset_int = 1'b0;
        #1;
        check_eq("ra_psel", 64'(PSEL), 64'(0));
        check_eq("ra_pen", 64'(PENABLE), 64'(0));
        check_eq("ra_busy", 64'(busy), 64'(0));
        PREADY = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq("ra_rspv_rst", 64'(rsp_valid), 64'(0));
        end
        reset_int = 1'b1;
        req_valid = 2'b11;
        #1;
        check_eq("ra_ptr0", 64'(req_ready), 64'(2'b01));
        tick();
        req_valid = 2'b00;
        check_eq("ra_rspv_s", 64'(rsp_valid), 64'(0));
        tick();
        check_eq("ra_rspv_a", 64'(rsp_valid), 64'(0));
        tick();
        check_eq("ra_rspv_new", 64'(rsp_valid), 64'(2'b01));

`ifdef STUDENT_APB_ARB_TIMEOUT_EN
        // PREADY never arrives: abort after four ACCESS cycles (pointer is 1)
        req_valid = 2'b10;
        req_write = 2'b00;
        PREADY = 1'b0;
        PRDATA = 32'h5555_5555;
        #1;
        check_eq("to_ready", 64'(req_ready), 64'(2'b10));
        tick();
        req_valid = 2'b00;
        tick();
        for (int k = 0; k < 4; k++) begin
            check_eq("to_pen", 64'(PENABLE), 64'(1));
            check_eq("to_rspv0", 64'(rsp_valid), 64'(0));
            tick();
        end
        check_eq("to_rspv", 64'(rsp_valid), 64'(2'b10));
        check_eq("to_err", 64'(rsp_err), 64'(1));
        check_eq("to_rdata", 64'(rsp_rdata), 64'(0));
        check_eq("to_busy", 64'(busy), 64'(0));
        check_eq("to_psel", 64'(PSEL), 64'(0));
        PREADY = 1'b1;
`endif

        tick();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
